// File: rtl/stats_sched_pkg.sv
// stats_sched_pkg
// Shared types and constants for the stat-bank update scheduler:
//   state_e       - scheduler FSM states
//   STAT_W        - width of one stat value and of the bank index
//   STAT_MAX      - saturation ceiling of a stat
//   NUM_STATS_DEF - default number of stats swept by decay
package stats_sched_pkg;

    localparam int STAT_W        = 3;
    localparam int STAT_MAX      = 7;
    localparam int NUM_STATS_DEF = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ACT = 3'd1,
        WR_ACT = 3'd2,
        RD_DEC = 3'd3,
        WR_DEC = 3'd4
    } state_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Free-running counter 0..TICK_DIV-1; emits a registered one-cycle tick
// each time the counter wraps.
// Ports:
//   clk   - system clock
//   Reset - asynchronous active-high reset
//   tick  - one-cycle decay tick pulse
module tick_divider #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic Reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/stats_update_scheduler.sv
// stats_update_scheduler
// Sole master of the stat register bank. Runs a periodic decay sweep that
// decrements every stat once per tick and interleaves user actions that
// increment one stat. Each bank access is a read cycle followed by a write
// cycle on the same index; strobes saturate at 0 and STAT_MAX.
// Optional feature macro: STATS_CRITICAL_EN (critical_mask tracking).
// Ports:
//   clk, Reset         - clock, asynchronous active-high reset
//   action_req/idx/ack - action handshake (req held until one-cycle ack)
//   reg_sel/up/down    - registered bank index and one-cycle strobes
//   stateValue         - combinational bank read of reg_sel
//   busy               - FSM not idle
//   tick_overrun       - sticky: tick arrived while one was pending
//   critical_mask      - bit i set when stat i reached 0 on its last decay
module stats_update_scheduler
    import stats_sched_pkg::*;
#(
    parameter int NUM_STATS = NUM_STATS_DEF,
    parameter int TICK_DIV  = 1000
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 action_req,
    input  logic [STAT_W-1:0]    action_idx,
    output logic                 action_ack,
    output logic [STAT_W-1:0]    reg_sel,
    output logic                 reg_up,
    output logic                 reg_down,
    input  logic [STAT_W-1:0]    stateValue,
    output logic                 busy,
    output logic                 tick_overrun,
    output logic [NUM_STATS-1:0] critical_mask
);

    localparam logic [STAT_W-1:0] NUM_L  = STAT_W'(NUM_STATS);
    localparam logic [STAT_W-1:0] LAST_L = STAT_W'(NUM_STATS - 1);
    localparam logic [STAT_W-1:0] MAX_L  = STAT_W'(STAT_MAX);

    logic tick;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .tick  (tick)
    );

    state_e            state_q, state_d;
    logic [STAT_W-1:0] idx_q, idx_d, sel_q, sel_d;
    logic              susp_q, susp_d, pend_q, pend_d, ovr_q, ovr_d;
    logic              up_q, up_d, down_q, down_d, ack_q, ack_d, busy_q, busy_d;
    logic              consume;
`ifdef STATS_CRITICAL_EN
    logic [STAT_W-1:0]    samp_q, samp_d;
    logic [NUM_STATS-1:0] mask_q, mask_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        susp_d  = susp_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        ack_d   = 1'b0;
        consume = 1'b0;
`ifdef STATS_CRITICAL_EN
        samp_d  = samp_q;
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (action_req) begin
                    state_d = RD_ACT;
                    sel_d   = action_idx;
                end else if (pend_q) begin
                    state_d = RD_DEC;
                    idx_d   = '0;
                    sel_d   = '0;
                    consume = 1'b1;
                end
            end
            // Strobe decisions are made from the read-phase value and
            // registered, so they appear exactly in the write cycle.
            RD_ACT: begin
                state_d = WR_ACT;
                ack_d   = 1'b1;
                up_d    = (action_idx < NUM_L) && (stateValue < MAX_L);
            end
            WR_ACT: begin
                if (susp_q) begin
                    state_d = RD_DEC;
                    sel_d   = idx_q;
                    susp_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_DEC: begin
                state_d = WR_DEC;
                down_d  = (stateValue != '0);
`ifdef STATS_CRITICAL_EN
                samp_d  = stateValue;
`endif
            end
            WR_DEC: begin
`ifdef STATS_CRITICAL_EN
                for (int i = 0; i < NUM_STATS; i++)
                    if (idx_q == STAT_W'(i)) mask_d[i] = (samp_q <= STAT_W'(1));
`endif
                if (idx_q == LAST_L) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    // Actions may only cut in at a stat boundary.
                    if (action_req) begin
                        susp_d  = 1'b1;
                        state_d = RD_ACT;
                        sel_d   = action_idx;
                    end else begin
                        state_d = RD_DEC;
                        sel_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // A tick landing on the cycle the pending one is consumed is a
        // fresh request, not an overrun.
        pend_d = (pend_q & ~consume) | tick;
        ovr_d  = ovr_q | (tick & pend_q & ~consume);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            susp_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            susp_q  <= susp_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            up_q    <= up_d;
            down_q  <= down_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

`ifdef STATS_CRITICAL_EN
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            samp_q <= '0;
            mask_q <= '0;
        end else begin
            samp_q <= samp_d;
            mask_q <= mask_d;
        end
    end
    assign critical_mask = mask_q;
`else
    assign critical_mask = '0;
`endif

    assign reg_sel      = sel_q;
    assign reg_up       = up_q;
    assign reg_down     = down_q;
    assign action_ack   = ack_q;
    assign busy         = busy_q;
    assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_stats_update_scheduler.sv
// tb_stats_update_scheduler
// Self-checking bench: a behavioural stat bank driven by the DUT, and a
// reference model that applies whole sweeps/actions with saturating
// arithmetic in the order the scheduler is expected to interleave them.
// A second instance with TICK_DIV=4 exercises tick overrun.
module tb_stats_update_scheduler;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       action_req = 1'b0;
    logic [2:0] action_idx = 3'd0;
    logic       action_ack, reg_up, reg_down, busy, tick_overrun;
    logic [2:0] reg_sel, state_value;
    logic [6:0] critical_mask;

    logic       b_ack, b_up, b_down, b_busy, b_ovr;
    logic [2:0] b_sel;
    logic [6:0] b_mask;

    stats_update_scheduler #(.NUM_STATS(7), .TICK_DIV(32)) dut (
        .clk(clk), .Reset(rst), .action_req(action_req), .action_idx(action_idx),
        .action_ack(action_ack), .reg_sel(reg_sel), .reg_up(reg_up), .reg_down(reg_down),
        .stateValue(state_value), .busy(busy), .tick_overrun(tick_overrun),
        .critical_mask(critical_mask)
    );

    stats_update_scheduler #(.NUM_STATS(7), .TICK_DIV(4)) dut_fast (
        .clk(clk), .Reset(rst), .action_req(1'b0), .action_idx(3'd0),
        .action_ack(b_ack), .reg_sel(b_sel), .reg_up(b_up), .reg_down(b_down),
        .stateValue(3'd3), .busy(b_busy), .tick_overrun(b_ovr),
        .critical_mask(b_mask)
    );

    // Behavioural bank: wraps on purpose so a missing saturation shows up.
    logic [2:0] bank    [0:7];
    logic [2:0] preload [0:7];
    logic       do_load = 1'b0;
    assign state_value = bank[reg_sel];
    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 8; i++) bank[i] <= preload[i];
        end else begin
            if (reg_up)   bank[reg_sel] <= bank[reg_sel] + 3'd1;
            if (reg_down) bank[reg_sel] <= bank[reg_sel] - 3'd1;
        end
    end

    // Strobe log: down on stat i -> i, up on stat j -> 8+j.
    int log_q[$];
    always @(negedge clk) begin
        if (reg_up)   log_q.push_back(8 + int'(reg_sel));
        if (reg_down) log_q.push_back(int'(reg_sel));
        if (!rst) begin
            checks++;
            if (reg_up && reg_down) begin
                errors++;
                $display("FAIL strobe_excl: up=%0b down=%0b, required not both", reg_up, reg_down);
            end
        end
    end

    // ---------------- reference model ----------------
    int         model[0:7];
    int         exp_log[$];
    logic [6:0] exp_mask = '0;

    task automatic model_action(input int j);
        if (j < 7 && model[j] < 7) begin
            exp_log.push_back(8 + j);
            model[j] = model[j] + 1;
        end
    endtask

    // Full sweep over stats 0..6; an action slips in after stat act_after.
    task automatic model_sweep(input int act_after, input int act_idx);
        exp_log.delete();
        for (int i = 0; i < 7; i++) begin
            exp_mask[i] = (model[i] <= 1);
            if (model[i] > 0) begin
                exp_log.push_back(i);
                model[i] = model[i] - 1;
            end
            if (i == act_after) model_action(act_idx);
        end
    endtask

    function automatic logic [6:0] mask_cfg();
`ifdef STATS_CRITICAL_EN
        return exp_mask;
`else
        return 7'd0;
`endif
    endfunction

    function automatic bit log_match();
        if (log_q.size() != exp_log.size()) return 1'b0;
        foreach (log_q[i]) if (log_q[i] != exp_log[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s %0d", s, q[i]);
        return s;
    endfunction

    function automatic bit bank_match();
        for (int i = 0; i < 7; i++) if (bank[i] !== 3'(model[i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string bank_str();
        string s = "";
        for (int i = 0; i < 7; i++) s = $sformatf("%s %0d/%0d", s, bank[i], model[i]);
        return s;
    endfunction

    task automatic load_model();
        for (int i = 0; i < 8; i++) preload[i] = (i < 7) ? 3'(model[i]) : 3'd0;
        do_load = 1'b1;
        @(posedge clk);
        #1 do_load = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_sweep_end();
        bit ok1, ok2;
        wait_busy(1'b1, ok1);
        wait_busy(1'b0, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL sweep_wait: busy edges seen=%0b%0b, required 11", ok1, ok2);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 7; i++) model[i] = 3;
        load_model();
        @(posedge clk); #1;
        checks++;
        if ({busy, action_ack, reg_up, reg_down, reg_sel, tick_overrun} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b ack=%0b up=%0b down=%0b sel=%0d ovr=%0b, required all 0",
                     busy, action_ack, reg_up, reg_down, reg_sel, tick_overrun);
        end
        checks++;
        if (critical_mask !== 7'd0) begin
            errors++;
            $display("FAIL reset_mask: got %b, required 0", critical_mask);
        end
        checks++;
        if ({b_busy, b_ovr, b_mask} !== 9'd0) begin
            errors++;
            $display("FAIL reset_fast: busy=%0b ovr=%0b mask=%b, required 0", b_busy, b_ovr, b_mask);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_sweep();
        bit ok;
        int len;
        log_q.delete();
        wait_busy(1'b1, ok);
        len = 0;
        while (busy === 1'b1 && len < 100) begin len++; @(negedge clk); end
        model_sweep(-1, 0);
        checks++;
        if (!ok || len != 14) begin
            errors++;
            $display("FAIL sweep_busy: started=%0b len=%0d, required 14", ok, len);
        end
        checks++;
        if (!log_match()) begin
            errors++;
            $display("FAIL sweep_log: got [%s ] required [%s ]", q_str(log_q), q_str(exp_log));
        end
        checks++;
        if (!bank_match()) begin
            errors++;
            $display("FAIL sweep_bank: got/required%s", bank_str());
        end
        checks++;
        if (critical_mask !== mask_cfg()) begin
            errors++;
            $display("FAIL sweep_mask: got %b required %b", critical_mask, mask_cfg());
        end
    endtask

    task automatic test_action();
        int lat, j;
        for (int r = 0; r < 6; r++) begin
            if (r > 0) wait_sweep_end();
            for (int i = 0; i < 7; i++) model[i] = int'($urandom_range(0, 7));
            j = (r < 2) ? 2 : int'($urandom_range(0, 7));
            if (r == 0) model[2] = 7;
            if (r == 1) model[2] = 4;
            load_model();
            log_q.delete();
            exp_log.delete();
            action_req = 1'b1;
            action_idx = 3'(j);
            lat = 0;
            do begin @(posedge clk); lat++; #1; end while (!action_ack && lat < 20);
            @(posedge clk); #1 action_req = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            model_action(j);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL action_lat r%0d: got %0d cycles, required 2", r, lat);
            end
            checks++;
            if (!log_match()) begin
                errors++;
                $display("FAIL action_log r%0d idx%0d: got [%s ] required [%s ]", r, j, q_str(log_q), q_str(exp_log));
            end
            checks++;
            if (!bank_match()) begin
                errors++;
                $display("FAIL action_bank r%0d: got/required%s", r, bank_str());
            end
        end
    endtask

    task automatic test_interleave();
        bit ok;
        int k, j, c0, lat;
        for (int r = 0; r < 4; r++) begin
            k = (r == 0) ? 3 : int'($urandom_range(0, 5));
            j = (r == 0) ? 5 : int'($urandom_range(0, 7));
            wait_sweep_end();
            for (int i = 0; i < 7; i++) model[i] = int'($urandom_range(0, 7));
            load_model();
            log_q.delete();
            wait_busy(1'b1, ok);
            c0 = cyc;
            repeat (2 * k) @(posedge clk);
            #1;
            action_req = 1'b1;
            action_idx = 3'(j);
            lat = 0;
            do begin @(posedge clk); lat++; #1; end while (!action_ack && lat < 40);
            @(posedge clk); #1 action_req = 1'b0;
            while (busy === 1'b1 && lat < 80) begin @(negedge clk); lat++; end
            model_sweep(k, j);
            checks++;
            if (!ok || cyc - c0 != 16) begin
                errors++;
                $display("FAIL inter_busy r%0d: started=%0b len=%0d, required 16", r, ok, cyc - c0);
            end
            checks++;
            if (!log_match()) begin
                errors++;
                $display("FAIL inter_log r%0d k%0d idx%0d: got [%s ] required [%s ]", r, k, j, q_str(log_q), q_str(exp_log));
            end
            checks++;
            if (!bank_match()) begin
                errors++;
                $display("FAIL inter_bank r%0d: got/required%s", r, bank_str());
            end
            checks++;
            if (critical_mask !== mask_cfg()) begin
                errors++;
                $display("FAIL inter_mask r%0d: got %b required %b", r, critical_mask, mask_cfg());
            end
        end
    endtask

    task automatic test_critical();
        wait_sweep_end();
        for (int i = 0; i < 7; i++) model[i] = 3;
        model[4] = 0;
        model[6] = 1;
        load_model();
        log_q.delete();
        wait_sweep_end();
        model_sweep(-1, 0);
        checks++;
        if (!log_match()) begin
            errors++;
            $display("FAIL crit_log: got [%s ] required [%s ]", q_str(log_q), q_str(exp_log));
        end
        checks++;
        if (!bank_match()) begin
            errors++;
            $display("FAIL crit_bank: got/required%s", bank_str());
        end
        checks++;
        if (critical_mask !== mask_cfg()) begin
            errors++;
            $display("FAIL crit_mask: got %b required %b", critical_mask, mask_cfg());
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (b_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %0b, required 1", b_ovr);
        end
        checks++;
        if (tick_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_main: got %0b, required 0", tick_overrun);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (b_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %0b, required 1", b_ovr);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_sweep_end();
        for (int i = 0; i < 7; i++) model[i] = 3;
        load_model();
        wait_busy(1'b1, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok || reg_down !== 1'b1 || reg_sel !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre: down=%0b sel=%0d, required down=1 sel=2", reg_down, reg_sel);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, action_ack, reg_up, reg_down, reg_sel, tick_overrun, critical_mask} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_out: busy=%0b up=%0b down=%0b sel=%0d mask=%b, required all 0",
                     busy, reg_up, reg_down, reg_sel, critical_mask);
        end
        @(posedge clk); #1;
        model[0] = 2;
        model[1] = 2;
        checks++;
        if (!bank_match()) begin
            errors++;
            $display("FAIL mid_abandon: got/required%s", bank_str());
        end
        @(negedge clk) rst = 1'b0;
        log_q.delete();
        wait_sweep_end();
        model_sweep(-1, 0);
        checks++;
        if (!log_match()) begin
            errors++;
            $display("FAIL mid_restart_log: got [%s ] required [%s ]", q_str(log_q), q_str(exp_log));
        end
        checks++;
        if (!bank_match()) begin
            errors++;
            $display("FAIL mid_restart_bank: got/required%s", bank_str());
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_action();
        test_interleave();
        test_critical();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/stats_update_scheduler.md
# stats_update_scheduler

Sequencer for the Tamagotchi stat register bank (7 × 3-bit need values addressed by a 3-bit index with increment and decrement strobes). It generates a periodic decay sweep that decrements every stat once per tick. It arbitrates that sweep against user actions such as feed and play, which increment one stat. It is the only master driving the bank's index and up/down strobes, and it keeps every value within 0..7.

## Interface
- NUM_STATS, 7, number of stats swept; 1..7.
- TICK_DIV, 1000, clock cycles per decay tick; ≥2.
- clk  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- action_req  in  1  user action request; held high until action_ack.
- action_idx  in  3  stat to increment; stable while action_req is high.
- action_ack  out  1  one-cycle pulse; action retired.
- reg_sel  out  3  bank index; registered.
- reg_up  out  1  bank increment strobe; registered, one cycle.
- reg_down  out  1  bank decrement strobe; registered, one cycle.
- stateValue  in  3  bank combinational read of reg_sel.
- busy  out  1  FSM not in IDLE.
- tick_overrun  out  1  sticky; a tick arrived while one was already pending.
- critical_mask  out  NUM_STATS  bit i set when stat i is 0 after its last decay step.

## Operation
- The tick divider counts 0..TICK_DIV-1 and issues a 1-cycle tick on wrap. A tick sets tick_pending.
- If a tick arrives while tick_pending is already set, tick_overrun is set and stays set until Reset.
- Each bank operation takes two cycles, a read phase then a write phase. The write phase always uses the same reg_sel as its read phase.
- FSM states: IDLE, RD_ACT, WR_ACT, RD_DEC, WR_DEC.
- From IDLE:
  - If action_req is high, go to RD_ACT.
  - Otherwise, if tick_pending is set, go to RD_DEC with idx=0 and clear tick_pending.
- RD_ACT: reg_sel=action_idx. The FSM samples stateValue, then goes to WR_ACT.
- WR_ACT:
  - Pulse reg_up only if action_idx < NUM_STATS and the sampled value < 7.
  - Pulse action_ack in every case.
  - Next state: RD_DEC if a sweep is suspended, otherwise IDLE.
- RD_DEC: reg_sel=idx. The FSM samples stateValue, then goes to WR_DEC.
- WR_DEC:
  - Pulse reg_down only if the sampled value > 0.
  - Update critical_mask[idx] to (sampled value ≤ 1).
  - After the last stat (idx = NUM_STATS-1), go to IDLE.
  - Otherwise increment idx. If action_req is high, mark the sweep suspended and go to RD_ACT; else go to RD_DEC.
- Arbitration: an action has priority over decay, but only at stat boundaries. A read/write pair is never split. A suspended sweep resumes at the saved idx.
- Only one of reg_up and reg_down is ever high in a given cycle.
- Saturation: no strobe is issued at 7 (up) or 0 (down). The FSM still spends both cycles.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the divider, idx, tick_pending and the suspend flag are all 0. Outputs drop immediately on Reset, including mid-operation. Any partial operation is abandoned with no strobe and no ack.
- Action latency with the FSM in IDLE: req seen at edge N → RD_ACT during cycle N+1 → ack and strobe during cycle N+2. The requester deasserts req in the cycle after ack.
- A full sweep takes 2·NUM_STATS cycles (14 by default), plus 2 cycles per interleaved action.
- The bank updates on the edge that ends the strobe cycle. The next operation's read phase sees the updated value.
- A tick that arrives during a sweep sets tick_pending. It is serviced after the sweep completes, not folded into the current sweep.
- When action_req and tick_pending are both present in IDLE, the action wins.

## Configuration
- STATS_CRITICAL_EN defined: critical_mask is computed as described above.
- STATS_CRITICAL_EN undefined: critical_mask is tied to 0 and its logic is removed. All other behaviour is unchanged.

## Structure
- Package stats_sched_pkg holds:
  - the FSM state enum;
  - STAT_MAX = 7;
  - STAT_W = 3;
  - the default NUM_STATS.
- Sub-module tick_divider holds the TICK_DIV counter and tick pulse. It takes clk and Reset and outputs tick.
- The FSM, pending/overrun flags and mask live in the top.

## Test plan
- TICK_DIV=32, all stats 3, no actions → after the first tick, busy is high for 14 cycles, there are 7 reg_down pulses for idx 0..6, all stats read 2, and critical_mask=0.
- Stat 2 = 7, action_req with idx 2 → ack 2 cycles after req, no reg_up, and stat 2 stays 7. Repeating with stat 2 = 4 → one reg_up, and stat 2 reads 5.
- action_req with idx 5 raised while the sweep is at idx 3 → the stat-3 pair completes, the action runs (stat 5 +1), the sweep resumes at idx 4, and busy lasts 16 cycles.
- Stat 4 = 0 and stat 6 = 1 before a sweep → no reg_down for idx 4, a reg_down for idx 6, and critical_mask = 7'b1010000 (0 without STATS_CRITICAL_EN).
- TICK_DIV=4 → a second tick arrives during the first sweep and the third arrives while still pending, so tick_overrun goes high and stays high.
- Reset asserted during WR_DEC at idx 2 → reg_down drops immediately, all outputs are 0, and after release the next tick's sweep restarts at idx 0.
